// File: rtl/pc_fetch_pkg.sv
// Shared constants, FSM state type and helpers for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_fetch_pkg;

   // Reset and rom chip-enable levels.
   localparam logic RST_ENABLE   = 1'b1;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Default PC / rom address width and instruction width.
   localparam int INST_ADDR_W = 32;
   localparam int INST_DATA_W = 32;

   // Fetch FSM states:
   //   IF_IDLE : single settling cycle after reset, rom disabled
   //   IF_RUN  : fetching from pc every cycle
   //   IF_ERR  : pc is misaligned, rom disabled until a flush redirects
   typedef enum logic [1:0] {
      IF_IDLE = 2'b00,
      IF_RUN  = 2'b01,
      IF_ERR  = 2'b10
   } if_state_t;

   // A fetch address is only legal on a 4-byte boundary.
   function automatic logic word_misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_if_id.sv
// IF/ID pipeline slot: captures {pc, inst} from fetch and counts valid captures.
// Latency: one cycle; whatever is presented at edge n is visible after edge n.
// Backpressure: stall holds the whole slot and the counter; flush clears the slot and wins over stall.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall, flush      hold / clear the slot this edge
//   cap_vld           fetch side has something real to capture this cycle
//   cap_adel          the capture is an address-error marker (instruction forced to 0)
//   cap_pc, cap_inst  captured pc and instruction
//   slot_pc/inst/vld/adel  registered IF/ID contents
//   fetch_cnt         number of valid captures, wraps at 2^32
module pc_fetch_if_id
   import pc_fetch_pkg::*;
#(
   parameter int AddrW = INST_ADDR_W,
   parameter int DataW = INST_DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             cap_vld,
   input  logic             cap_adel,
   input  logic [AddrW-1:0] cap_pc,
   input  logic [DataW-1:0] cap_inst,
   output logic [AddrW-1:0] slot_pc,
   output logic [DataW-1:0] slot_inst,
   output logic             slot_vld,
   output logic             slot_adel,
   output logic [31:0]      fetch_cnt
);

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         slot_pc   <= '0;
         slot_inst <= '0;
         slot_vld  <= 1'b0;
         slot_adel <= 1'b0;
         fetch_cnt <= ZERO_WORD;
      end else if (flush) begin
         // Flush kills whatever is in flight; the counter is untouched.
         slot_pc   <= '0;
         slot_inst <= '0;
         slot_vld  <= 1'b0;
         slot_adel <= 1'b0;
      end else if (stall) begin
         // Decode re-presents the same instruction; hold everything.
         slot_pc   <= slot_pc;
         slot_inst <= slot_inst;
         slot_vld  <= slot_vld;
         slot_adel <= slot_adel;
      end else if (cap_vld) begin
         // An address-error capture carries its pc for EPC/BadVAddr but no
         // instruction bits, since the rom was never enabled for it.
         slot_pc   <= cap_pc;
         slot_inst <= cap_adel ? '0 : cap_inst;
         slot_vld  <= 1'b1;
         slot_adel <= cap_adel;
         fetch_cnt <= fetch_cnt + 32'd1;
      end else begin
         slot_pc   <= '0;
         slot_inst <= '0;
         slot_vld  <= 1'b0;
         slot_adel <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, drives the rom and fills the IF/ID slot.
// Latency: pc presented at edge n appears in IF/ID after edge n+1; a flush target is fetched the cycle after the flush edge.
// Backpressure: stall_i freezes pc and IF/ID (branches ignored meanwhile); flush_i overrides stall and everything else.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall_i                        hold pc and IF/ID
//   flush_i, flush_pc_i            exception/eret redirect (highest priority)
//   branch_flag_i, branch_target_i taken branch resolved in ID
//   rom_ce_o, rom_addr_o           rom enable and byte address (= pc)
//   rom_inst_i                     combinational rom read data
//   id_pc_o/id_inst_o/id_valid_o/id_adel_o   IF/ID slot
//   fetch_cnt_o                    count of valid IF/ID captures
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter int               AddrW   = INST_ADDR_W,
   parameter int               DataW   = INST_DATA_W,
   parameter logic [AddrW-1:0] ResetPC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [AddrW-1:0] flush_pc_i,
   input  logic             branch_flag_i,
   input  logic [AddrW-1:0] branch_target_i,
   output logic             rom_ce_o,
   output logic [AddrW-1:0] rom_addr_o,
   input  logic [DataW-1:0] rom_inst_i,
   output logic [AddrW-1:0] id_pc_o,
   output logic [DataW-1:0] id_inst_o,
   output logic             id_valid_o,
   output logic             id_adel_o,
   output logic [31:0]      fetch_cnt_o
);

   if_state_t        state, state_nxt;
   logic [AddrW-1:0] pc, pc_nxt;
   // Set for exactly the first (non-stalled) cycle spent in IF_ERR after the
   // misaligned pc was loaded, so the AdEL marker reaches IF/ID only once.
   logic             err_fresh, err_fresh_nxt;
   logic             cap_vld;
   logic             cap_adel;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= IF_IDLE;
         pc        <= ResetPC;
         err_fresh <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         err_fresh <= err_fresh_nxt;
      end
   end

   always_comb begin
      pc_nxt        = pc;
      state_nxt     = state;
      err_fresh_nxt = err_fresh;

      // Sequential pc selection; branches are only acted on in RUN when not
      // stalled, because ID keeps re-presenting a stalled branch.
      if (state == IF_RUN && !stall_i) begin
         if (branch_flag_i) begin
            pc_nxt = branch_target_i;
         end else begin
            pc_nxt = pc + AddrW'(4);
         end
      end

      if (flush_i) begin
         pc_nxt = flush_pc_i;
      end

      // ERR is sticky until a flush; every other path checks the alignment
      // of whatever pc it is about to load.
      if (state == IF_ERR && !flush_i) begin
         state_nxt = IF_ERR;
      end else if (word_misaligned(pc_nxt[1:0])) begin
         state_nxt = IF_ERR;
      end else begin
         state_nxt = IF_RUN;
      end

      // A new misaligned pc (from RUN/IDLE, or a flush landing on another
      // misaligned target) re-arms the AdEL marker. A stall while the marker
      // is pending keeps it pending because IF/ID did not take it.
      if (state_nxt == IF_ERR && (state != IF_ERR || flush_i)) begin
         err_fresh_nxt = 1'b1;
      end else if (state != IF_ERR || !stall_i) begin
         err_fresh_nxt = 1'b0;
      end
   end

   assign rom_addr_o = pc;
   assign rom_ce_o   = (state == IF_RUN) ? CHIP_ENABLE : CHIP_DISABLE;

   // RUN captures the rom word; the first ERR cycle captures the AdEL marker;
   // IDLE and later ERR cycles insert bubbles.
   assign cap_vld  = (state == IF_RUN) || (state == IF_ERR && err_fresh);
   assign cap_adel = (state == IF_ERR);

   pc_fetch_if_id #(
      .AddrW (AddrW),
      .DataW (DataW)
   ) u_if_id (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall_i),
      .flush     (flush_i),
      .cap_vld   (cap_vld),
      .cap_adel  (cap_adel),
      .cap_pc    (pc),
      .cap_inst  (rom_inst_i),
      .slot_pc   (id_pc_o),
      .slot_inst (id_inst_o),
      .slot_vld  (id_valid_o),
      .slot_adel (id_adel_o),
      .fetch_cnt (fetch_cnt_o)
   );

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by random stall/flush/branch/reset
// traffic, all checked every cycle against a behavioural model of the fetch rules.
module tb_pc_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, flush, br;
   logic [31:0] flush_pc, tgt;

   logic        rom_ce_a, id_valid_a, id_adel_a;
   logic [31:0] rom_addr_a, rom_inst_a, id_pc_a, id_inst_a, cnt_a;
   logic        rom_ce_b, id_valid_b, id_adel_b;
   logic [31:0] rom_addr_b, rom_inst_b, id_pc_b, id_inst_b, cnt_b;

   int n_pass  = 0;
   int n_total = 0;

   // Instruction rom: word i holds 32'h1000_0000 + i.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign rom_inst_a = rom_ce_a ? rom_word(rom_addr_a) : 32'h0;
   assign rom_inst_b = rom_ce_b ? rom_word(rom_addr_b) : 32'h0;

   pc_fetch #(.ResetPC(32'h0000_0000)) dut_a (
      .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .flush_pc_i(flush_pc),
      .branch_flag_i(br), .branch_target_i(tgt),
      .rom_ce_o(rom_ce_a), .rom_addr_o(rom_addr_a), .rom_inst_i(rom_inst_a),
      .id_pc_o(id_pc_a), .id_inst_o(id_inst_a), .id_valid_o(id_valid_a),
      .id_adel_o(id_adel_a), .fetch_cnt_o(cnt_a)
   );

   pc_fetch #(.ResetPC(32'hBFC0_0000)) dut_b (
      .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0), .flush_pc_i(32'h0),
      .branch_flag_i(1'b0), .branch_target_i(32'h0),
      .rom_ce_o(rom_ce_b), .rom_addr_o(rom_addr_b), .rom_inst_i(rom_inst_b),
      .id_pc_o(id_pc_b), .id_inst_o(id_inst_b), .id_valid_o(id_valid_b),
      .id_adel_o(id_adel_b), .fetch_cnt_o(cnt_b)
   );

   // ---------------- behavioural model of dut_a ----------------
   logic [31:0] m_pc;      // address currently being fetched
   bit          m_idle;    // settling cycle after reset
   bit          m_fault;   // pc misaligned, fetching suspended
   bit          m_fresh;   // AdEL marker not yet delivered to decode
   logic [31:0] e_pc, e_inst, e_cnt;
   bit          e_vld, e_adel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_edge();
      logic [31:0] npc;
      if (rst) begin
         m_pc = 32'h0; m_idle = 1; m_fault = 0; m_fresh = 0;
         e_pc = 0; e_inst = 0; e_vld = 0; e_adel = 0; e_cnt = 0;
         return;
      end
      // decode slot
      if (flush) begin
         e_pc = 0; e_inst = 0; e_vld = 0; e_adel = 0;
      end else if (!stall) begin
         if (!m_idle && !m_fault) begin
            e_pc = m_pc; e_inst = rom_word(m_pc); e_vld = 1; e_adel = 0; e_cnt++;
         end else if (m_fault && m_fresh) begin
            e_pc = m_pc; e_inst = 0; e_vld = 1; e_adel = 1; e_cnt++;
         end else begin
            e_pc = 0; e_inst = 0; e_vld = 0; e_adel = 0;
         end
      end
      // program counter
      if (flush)                          npc = flush_pc;
      else if (m_idle || m_fault || stall) npc = m_pc;
      else if (br)                        npc = tgt;
      else                                npc = m_pc + 32'd4;
      if (flush || !m_fault) begin
         m_fault = (npc % 4) != 0;
         m_fresh = m_fault;
      end else if (!stall) begin
         m_fresh = 0;
      end
      m_pc   = npc;
      m_idle = 0;
   endtask

   // One clock: advance the model, let the DUT take the edge, compare.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("rom_ce",    {31'b0, rom_ce_a},   {31'b0, !m_idle && !m_fault});
      chk("rom_addr",  rom_addr_a,          m_pc);
      chk("id_pc",     id_pc_a,             e_pc);
      chk("id_inst",   id_inst_a,           e_inst);
      chk("id_valid",  {31'b0, id_valid_a}, {31'b0, e_vld});
      chk("id_adel",   {31'b0, id_adel_a},  {31'b0, e_adel});
      chk("fetch_cnt", cnt_a,               e_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; stall = 0; flush = 0; br = 0; flush_pc = 0; tgt = 0;

      // 1: reset, release, sequential fetch
      repeat (3) step();
      chk("rst_ce",     {31'b0, rom_ce_a},   32'h0);
      chk("rst_cnt",    cnt_a,               32'h0);
      chk("rst_valid",  {31'b0, id_valid_a}, 32'h0);
      chk("b_rst_addr", rom_addr_b,          32'hBFC0_0000);
      chk("b_rst_ce",   {31'b0, rom_ce_b},   32'h0);
      rst = 0;
      step();
      chk("t1_addr0",   rom_addr_a,          32'h0);
      chk("t1_ce_on",   {31'b0, rom_ce_a},   32'h1);
      chk("b_ce_on",    {31'b0, rom_ce_b},   32'h1);
      step();
      chk("t1_inst0",   id_inst_a,           32'h1000_0000);
      chk("b_id_pc",    id_pc_b,             32'hBFC0_0000);
      chk("b_id_inst",  id_inst_b,           32'h3FF0_0000);
      chk("b_id_valid", {31'b0, id_valid_b}, 32'h1);
      chk("b_id_adel",  {31'b0, id_adel_b},  32'h0);
      chk("b_cnt",      cnt_b,               32'h1);
      step();
      chk("t1_inst1",   id_inst_a,           32'h1000_0001);
      step();
      chk("t1_addr_c",  rom_addr_a,          32'h0C);

      // 2: stall two cycles at pc 0x0C
      stall = 1;
      step(); step();
      chk("t2_addr_hold", rom_addr_a, 32'h0C);
      chk("t2_idpc_hold", id_pc_a,    32'h08);
      chk("t2_cnt_hold",  cnt_a,      32'd3);
      stall = 0;
      step();
      chk("t2_resume", rom_addr_a, 32'h10);

      // 3: branch with delay slot
      step();
      chk("t3_id_10", id_pc_a, 32'h10);
      br = 1; tgt = 32'h40;
      step();
      chk("t3_id_14", id_pc_a, 32'h14);
      br = 0;
      step();
      chk("t3_id_40", id_pc_a, 32'h40);
      step();
      chk("t3_id_44", id_pc_a, 32'h44);

      // 4: misaligned branch target, AdEL, recovery via flush
      br = 1; tgt = 32'h42;
      step();
      chk("t4_ce_off", {31'b0, rom_ce_a}, 32'h0);
      br = 0;
      step();
      chk("t4_adel_pc",   id_pc_a,             32'h42);
      chk("t4_adel",      {31'b0, id_adel_a},  32'h1);
      chk("t4_adel_inst", id_inst_a,           32'h0);
      step();
      chk("t4_bubble",    {31'b0, id_valid_a}, 32'h0);
      flush = 1; flush_pc = 32'h80;
      step();
      flush = 0;
      step();
      chk("t4_resume", id_inst_a, 32'h1000_0020);

      // 5: flush + stall + branch in the same cycle
      flush = 1; stall = 1; br = 1; flush_pc = 32'h100; tgt = 32'h40;
      step();
      chk("t5_bubble", {31'b0, id_valid_a}, 32'h0);
      flush = 0; stall = 0; br = 0;
      step();
      chk("t5_fetch", id_pc_a, 32'h100);

      // pc+4 wraps at the top of the address space
      flush = 1; flush_pc = 32'hFFFF_FFFC;
      step();
      flush = 0;
      step();
      chk("wrap_addr", rom_addr_a, 32'h0);

      // 6: mid-stream reset at pc 0x20
      flush = 1; flush_pc = 32'h18;
      step();
      flush = 0;
      step(); step();
      chk("t6_pc20", rom_addr_a, 32'h20);
      rst = 1;
      step();
      chk("t6_pc0", rom_addr_a, 32'h0);
      chk("t6_cnt", cnt_a,      32'h0);
      rst = 0;

      // random traffic
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom % 97) == 0;
         stall = ($urandom % 5) == 0;
         flush = ($urandom % 13) == 0;
         br    = ($urandom % 4) == 0;
         flush_pc = {$urandom_range(0, 255), 2'b00} |
                    (($urandom % 4 == 0) ? 32'($urandom % 4) : 32'h0);
         tgt      = {$urandom_range(0, 255), 2'b00} |
                    (($urandom % 8 == 0) ? 32'($urandom % 4) : 32'h0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
